// File: rtl/led_pattern_seq.sv
// rtl/led_pattern_seq.sv - LED pattern sequencer with step timer, four patterns, speed select and single-step
module led_pattern_seq #(
  parameter int LED_W      = 6,
  parameter int TICK_DIV   = 3_500_000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [1:0]       mode,
  input  logic             run,
  input  logic [1:0]       speed,
  input  logic             step,
  output logic [LED_W-1:0] led,
  output logic             step_stb,
  output logic             wrap_stb
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [LED_W-1:0] PAT_ONE  = LED_W'(1);
  localparam logic [LED_W-1:0] PAT_ZERO = '0;

  localparam logic [1:0] MODE_ROL    = 2'b00;
  localparam logic [1:0] MODE_ROR    = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;
  localparam logic [1:0] MODE_COUNT  = 2'b11;

  typedef enum logic {
    DIR_LEFT  = 1'b0,
    DIR_RIGHT = 1'b1
  } dir_t;

  logic [LED_W-1:0] r_pat;
  logic [CNT_W-1:0] r_cnt;
  dir_t             r_dir;
  logic [1:0]       r_mode_q;
  logic             r_step_q;
  logic             r_step_stb;
  logic             r_wrap_stb;

  logic [LED_W-1:0] w_pat_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  dir_t             w_dir_nxt;
  logic             w_step_stb_nxt;
  logic             w_wrap_stb_nxt;
  logic [31:0]      w_per;
  logic             w_mode_chg;
  logic             w_tick;
  logic             w_manual;
  logic             w_adv;

  // Step period at the selected speed and the advance request sources.
  always_comb begin
    w_per      = 32'(TICK_DIV) >> speed;
    w_mode_chg = (mode != r_mode_q);
    // >= rather than == so that a mid-count speed-up past the new limit advances at once
    w_tick     = run && (32'(r_cnt) >= (w_per - 32'd1));
    w_manual   = !run && step && !r_step_q;
    w_adv      = !w_mode_chg && (w_tick || w_manual);
  end

  // Next-state logic: mode reinit has priority, otherwise timer upkeep and pattern advance.
  always_comb begin
    w_pat_nxt      = r_pat;
    w_cnt_nxt      = r_cnt;
    w_dir_nxt      = r_dir;
    w_step_stb_nxt = 1'b0;
    w_wrap_stb_nxt = 1'b0;

    if (w_mode_chg) begin
      w_pat_nxt = (mode == MODE_COUNT) ? PAT_ZERO : PAT_ONE;
      w_dir_nxt = DIR_LEFT;
      w_cnt_nxt = '0;
    end else begin
      if (!run || w_tick) begin
        w_cnt_nxt = '0;
      end else begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
      end

      if (w_adv) begin
        w_step_stb_nxt = 1'b1;
        case (r_mode_q)
          MODE_ROL: begin
            w_pat_nxt      = {r_pat[LED_W-2:0], r_pat[LED_W-1]};
            w_wrap_stb_nxt = (w_pat_nxt == PAT_ONE);
          end
          MODE_ROR: begin
            w_pat_nxt      = {r_pat[0], r_pat[LED_W-1:1]};
            w_wrap_stb_nxt = (w_pat_nxt == PAT_ONE);
          end
          MODE_BOUNCE: begin
            // Direction flips on the edge that reaches an end, so end LEDs light once per pass
            if (r_dir == DIR_LEFT) begin
              w_pat_nxt = r_pat << 1;
              if (w_pat_nxt[LED_W-1]) w_dir_nxt = DIR_RIGHT;
            end else begin
              w_pat_nxt = r_pat >> 1;
              if (w_pat_nxt[0]) w_dir_nxt = DIR_LEFT;
            end
            w_wrap_stb_nxt = (w_pat_nxt == PAT_ONE);
          end
          default: begin
            w_pat_nxt      = r_pat + PAT_ONE;
            w_wrap_stb_nxt = (w_pat_nxt == PAT_ZERO);
          end
        endcase
      end
    end
  end

  // State registers; reset clears immediately without waiting for a clock edge.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_pat      <= PAT_ONE;
      r_cnt      <= '0;
      r_dir      <= DIR_LEFT;
      r_mode_q   <= MODE_ROL;
      r_step_q   <= 1'b0;
      r_step_stb <= 1'b0;
      r_wrap_stb <= 1'b0;
    end else begin
      r_pat      <= w_pat_nxt;
      r_cnt      <= w_cnt_nxt;
      r_dir      <= w_dir_nxt;
      r_mode_q   <= mode;
      r_step_q   <= step;
      r_step_stb <= w_step_stb_nxt;
      r_wrap_stb <= w_wrap_stb_nxt;
    end
  end

  assign led      = (ACTIVE_LOW != 0) ? ~r_pat : r_pat;
  assign step_stb = r_step_stb;
  assign wrap_stb = r_wrap_stb;

endmodule

// File: doc/led_pattern_seq.md
Name: led_pattern_seq

Overview:
Parametrised LED pattern sequencer that drives an LED bank from a free-running step timer. It generalises the single-LED rotator in four ways: configurable LED count, tick period and output polarity; four runtime-selectable patterns; speed select; and a paused single-step mode. It sits directly between the board clock/reset and the LED pins. It also exports step and wrap strobes for use by other logic.

Parameters:
LED_W, 6, number of LEDs; legal range 2..32.
TICK_DIV, 3_500_000, sys_clk cycles per step at speed 0; must be at least 8.
ACTIVE_LOW, 1, 1 means the pin is driven low for a lit LED (led = ~pat); 0 means led = pat.

Ports:
sys_clk  in  1  system clock
sys_rst_n  in  1  reset, asynchronous assert, active-low
mode  in  2  00 rotate-left, 01 rotate-right, 10 bounce, 11 binary count
run  in  1  1 = timer-driven stepping, 0 = paused
speed  in  2  step period = TICK_DIV >> speed
step  in  1  manual advance request; rising-edge detected; honoured only while run=0
led  out  LED_W  LED pin drive (registered)
step_stb  out  1  one-cycle pulse, coincident with each new led value
wrap_stb  out  1  one-cycle pulse, coincident with step_stb when the pattern returns to its initial value

Behaviour:
- Clock and reset (already decided): one clock, sys_clk. Reset is asynchronous and active-low, sys_rst_n.
- Internal state: pat[LED_W-1:0] (active-high, 1 = lit); cnt, width clog2(TICK_DIV); dir (0 = left); mode_q; step_q.
- led is always ACTIVE_LOW ? ~pat : pat.
- Reset values: pat = 1 (bit0 lit), so led = 111110 for the default parameters. Also cnt = 0, dir = 0, mode_q = 00, step_q = 0, step_stb = 0, wrap_stb = 0.
- Reset takes effect immediately, with no clock edge, including mid-count.
- Period: per = TICK_DIV >> speed (speed 3 gives TICK_DIV/8).
- Timer advance, run=1: cnt increments each cycle. When cnt >= per-1, an advance occurs on that edge and cnt returns to 0.
  - The >= comparison matters: a speed increase mid-count with cnt already at or past the new per-1 advances on the very next edge.
- Paused, run=0:
  - cnt is held at 0.
  - A step rising edge (step=1, step_q=0) advances on that edge.
  - Holding step high gives exactly one advance.
  - step is ignored while run=1.
- Advance rules; pat, step_stb and wrap_stb all update on the same edge:
  - 00 rotate-left: pat = {pat[LED_W-2:0], pat[LED_W-1]}. Wrap when the new pat = 1.
  - 01 rotate-right: pat = {pat[0], pat[LED_W-1:1]}. Wrap when the new pat = 1.
  - 10 bounce:
    - dir=0: pat << 1.
    - dir=1: pat >> 1.
    - dir flips on the edge where the new pat reaches bit LED_W-1 (flip to 1) or bit0 (flip to 0), so end LEDs are not repeated.
    - Period is 2*(LED_W-1) steps. Wrap when the new pat = 1.
  - 11 binary count: pat = pat + 1, modulo 2^LED_W. Wrap when the new pat = 0.
- Mode change:
  - When mode != mode_q, on that edge mode_q <= mode and cnt <= 0.
  - pat is reinitialised: 1 for modes 00/01/10, 0 for mode 11. dir is set to 0.
  - No advance and no strobes occur on the reinit edge; this takes priority over a coincident advance.
- Changing run or speed does not alter pat.
- Pattern invariant: in modes 00/01/10 pat is always one-hot.
- No combinational path from any input to led.

Test Plan:
Common settings: LED_W=6, TICK_DIV=16, ACTIVE_LOW=1.
1. Release reset with run=1, mode=00, speed=00. Required: led=111110. The first change to 111101 comes on the 16th posedge after release, with step_stb high for 1 cycle. After 6 steps led=111110 again, with wrap_stb=1 on that step only.
2. mode=01 from reset. Required sequence: 111110 → 011111 → 101111 → 110111 → 111011 → 111101 → 111110. wrap_stb fires on the last step.
3. mode=10. Required lit-bit sequence: 0,1,2,3,4,5,4,3,2,1,0. No repeated end LED. wrap_stb fires once, at step 10.
4. mode=11, speed=11 (per=2). Required: pat counts 0..63 with led = ~pat. wrap_stb fires on 63→0. Switching to mode=00 mid-count gives led=111110 on the next edge, with no strobe.
5. run=0, then step held high for 3 cycles, then 2 further single-cycle pulses. Required: exactly 3 advances in total, cnt stays 0, and a step pulse while run=1 produces no extra advance.
6. Two cases:
   - run=1, speed=00, cnt=10, then switch to speed=10 (per=4). Required: advance on the next edge.
   - Assert sys_rst_n low between clock edges. Required: led returns to 111110 with no clock edge, and both strobes go to 0.
